// File: rtl/case_6_mul_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// case_6_mul_pkg : shared constants, index type and round-robin pick helper
// Rev 1.0
// ----------------------------------------------------------------------------
package case_6_mul_pkg;

  localparam int DIN_WIDTH  = 8;
  localparam int DOUT_WIDTH = 10;
  localparam int MAX_REQ    = 8;

  typedef logic [2:0] req_idx_t;

  // Returns {found, index}: first valid at or after ptr, wrapping modulo num.
  function automatic logic [3:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input req_idx_t           ptr,
    input logic [3:0]         num
  );
    logic [3:0] r;
    logic [3:0] idx;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= num) idx = idx - num;
      if ((4'(k) < num) && !r[3] && valid[idx[2:0]]) r = {1'b1, idx[2:0]};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/case_6_mul_8s_8s_10_1_1.sv
`default_nettype none
// ----------------------------------------------------------------------------
// case_6_mul_8s_8s_10_1_1 : combinational signed multiplier, truncated output
// Rev 1.0
// ----------------------------------------------------------------------------
module case_6_mul_8s_8s_10_1_1
  import case_6_mul_pkg::*;
#(
  parameter int IN_W  = DIN_WIDTH,
  parameter int OUT_W = DOUT_WIDTH
) (
  input  logic [IN_W-1:0]  i_din0,
  input  logic [IN_W-1:0]  i_din1,
  output logic [OUT_W-1:0] o_dout
);

  logic signed [2*IN_W-1:0] w_prod;

  assign w_prod = $signed(i_din0) * $signed(i_din1);
  assign o_dout = w_prod[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/case_6_mul_rr_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// case_6_mul_rr_sched : round-robin sharing of one signed multiplier
// Rev 1.0
// ----------------------------------------------------------------------------
module case_6_mul_rr_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DIN_WIDTH  = 8,
  parameter int DOUT_WIDTH = 10,
  parameter int ID_WIDTH   = 2
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DIN_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DIN_WIDTH-1:0] req_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [DOUT_WIDTH-1:0]        res_data,
  output logic [ID_WIDTH-1:0]          res_id,
  output logic                         busy
);
  import case_6_mul_pkg::*;

  localparam logic [ID_WIDTH-1:0] c_last = ID_WIDTH'(NUM_REQ - 1);

  logic                  r_res_valid;
  logic [DOUT_WIDTH-1:0] r_res_data;
  logic [ID_WIDTH-1:0]   r_res_id;
  logic [ID_WIDTH-1:0]   r_rr_ptr;

  logic [MAX_REQ-1:0]    w_valid_ext;
  logic [3:0]            w_pick;
  logic                  w_found;
  req_idx_t              w_idx;
  logic [ID_WIDTH-1:0]   w_gnt_id;
  logic                  w_can_issue;
  logic                  w_grant;
  logic [DIN_WIDTH-1:0]  w_a;
  logic [DIN_WIDTH-1:0]  w_b;
  logic [DOUT_WIDTH-1:0] w_prod;

  assign w_valid_ext      = MAX_REQ'(req_valid);
  assign w_pick           = rr_pick(w_valid_ext, req_idx_t'(r_rr_ptr), 4'(NUM_REQ));
  assign {w_found, w_idx} = w_pick;
  assign w_gnt_id         = ID_WIDTH'(w_idx);

  // Reset suppresses the grant so nothing is accepted in the reset cycle.
  assign w_can_issue = !r_res_valid || res_ready;
  assign w_grant     = w_can_issue && w_found && !ap_rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant && (w_idx == req_idx_t'(i))) req_ready[i] = 1'b1;
    end
  end

  assign w_a = req_a[w_idx*DIN_WIDTH +: DIN_WIDTH];
  assign w_b = req_b[w_idx*DIN_WIDTH +: DIN_WIDTH];

  case_6_mul_8s_8s_10_1_1 #(
    .IN_W  (DIN_WIDTH),
    .OUT_W (DOUT_WIDTH)
  ) u_mul (
    .i_din0 (w_a),
    .i_din1 (w_b),
    .o_dout (w_prod)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_grant) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_prod;
      r_res_id    <= w_gnt_id;
      r_rr_ptr    <= (w_gnt_id == c_last) ? '0 : w_gnt_id + 1'b1;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign busy      = r_res_valid || (|req_valid);

endmodule
`default_nettype wire

// File: tb/tb_case_6_mul_rr_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_case_6_mul_rr_sched : directed corners plus randomized traffic vs. model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_case_6_mul_rr_sched;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 10;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [OW-1:0]   res_data;
  logic [IW-1:0]   res_id;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  case_6_mul_rr_sched #(
    .NUM_REQ(N), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .ID_WIDTH(IW)
  ) dut (
    .ap_clk(clk), .ap_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int prod10(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p & ((1 << OW) - 1);
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Reference model: output register contents and rotating priority pointer.
  bit m_valid = 1'b0;
  int m_data  = 0;
  int m_id    = 0;
  int m_ptr   = 0;

  initial begin
    @(posedge clk);
    forever begin
      int g;
      @(negedge clk);
      g = -1;
      if (!rst && (!m_valid || res_ready)) g = pick(req_valid, m_ptr);
      chk("ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      chk("res_valid", 32'(res_valid), 32'(m_valid));
      chk("res_data", 32'(res_data), 32'(m_data));
      chk("res_id", 32'(res_id), 32'(m_id));
      chk("busy", 32'(busy), 32'(m_valid || (|req_valid)));
      if (rst) begin
        m_valid = 1'b0; m_data = 0; m_id = 0; m_ptr = 0;
      end else if (g >= 0) begin
        m_data  = prod10(req_a[g*DW +: DW], req_b[g*DW +: DW]);
        m_id    = g;
        m_valid = 1'b1;
        m_ptr   = (g + 1) % N;
      end else if (res_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input int i, input bit v, input int a, input int b);
    req_valid[i]       = v;
    req_a[i*DW +: DW]  = DW'(a);
    req_b[i*DW +: DW]  = DW'(b);
  endtask

  function automatic int rnd_op();
    int sel;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0: return 127;
      1: return -128;
      2: return 0;
      3: return -1;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  int c_a[4]   = '{127, -128, -128, 0};
  int c_b[4]   = '{127, -128, 127, -77};
  int c_exp[4] = '{'h301, 'h000, 'h080, 'h000};
  int g_seq[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    logic [N-1:0] acc;
    tick; tick;
    rst = 1'b0;

    // single request, one-cycle latency
    setreq(0, 1'b1, -3, 5);
    res_ready = 1'b1;
    @(negedge clk); chk("t1_ready", 32'(req_ready), 32'h1);
    tick; req_valid = '0;
    @(negedge clk);
    chk("t1_valid", 32'(res_valid), 32'h1);
    chk("t1_data", 32'(res_data), 32'h3F1);
    chk("t1_id", 32'(res_id), 32'h0);

    // truncation corners
    for (int k = 0; k < 4; k++) begin
      tick; setreq(0, 1'b1, c_a[k], c_b[k]);
      tick; req_valid = '0;
      @(negedge clk); chk("t4_trunc", 32'(res_data), 32'(c_exp[k]));
    end

    // all requesters continuously valid from a fresh pointer
    tick; rst = 1'b1;
    tick; rst = 1'b0;
    for (int i = 0; i < N; i++) setreq(i, 1'b1, i + 2, -(i + 3));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); chk("t2_grant", 32'(req_ready), 32'd1 << g_seq[k]);
      tick;
    end
    req_valid = '0;

    // backpressure with req1/req2 waiting (pointer moved to 1 first)
    setreq(0, 1'b1, 7, -9);
    tick; req_valid = '0; res_ready = 1'b0;
    setreq(1, 1'b1, 3, 3);
    setreq(2, 1'b1, 5, 6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_ready", 32'(req_ready), 32'h0);
      chk("t3_data", 32'(res_data), 32'h3C1);
      chk("t3_id", 32'(res_id), 32'h0);
      tick;
    end
    res_ready = 1'b1;
    @(negedge clk); chk("t3_grant", 32'(req_ready), 32'h2);
    tick; req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t3_valid", 32'(res_valid), 32'h1);
    chk("t3_id1", 32'(res_id), 32'h1);
    tick; req_valid[2] = 1'b0;

    // pointer at 3: wrap search, then 3 ahead of 1
    setreq(1, 1'b1, -2, 9);
    @(negedge clk); chk("t5_wrap", 32'(req_ready), 32'h2);
    tick; req_valid[1] = 1'b0;
    setreq(3, 1'b1, 4, 4);
    setreq(1, 1'b1, 1, 1);
    @(negedge clk); chk("t5_g3", 32'(req_ready), 32'h8);
    tick; req_valid[3] = 1'b0;
    @(negedge clk); chk("t5_g1", 32'(req_ready), 32'h2);
    tick; req_valid[1] = 1'b0;

    // reset while a result is pending and req2 is waiting
    res_ready = 1'b0;
    setreq(2, 1'b1, 11, -5);
    tick; rst = 1'b1;
    @(negedge clk); chk("t6_rst_ready", 32'(req_ready), 32'h0);
    tick; rst = 1'b0;
    @(negedge clk); chk("t6_cleared", 32'(res_valid), 32'h0);
    tick; res_ready = 1'b1;
    @(negedge clk); chk("t6_grant", 32'(req_ready), 32'h4);
    tick; req_valid[2] = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(res_valid), 32'h1);
    chk("t6_id", 32'(res_id), 32'h2);
    chk("t6_data", 32'(res_data), 32'(prod10(8'd11, 8'hFB)));
    tick;
    @(negedge clk); chk("t6_once", 32'(res_valid), 32'h0);
    tick;

    // randomized traffic obeying hold-until-accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && ($urandom_range(0, 2) == 0)) setreq(i, 1'b1, rnd_op(), rnd_op());
      end
      res_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    req_valid = '0;
    tick; tick;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
